// File: rtl/hybrid_tree_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hybrid_tree_pkg: shared types and helpers for hybrid-tree heap    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package hybrid_tree_pkg;

  typedef enum logic [1:0] {
    LVL_INIT = 2'd0,
    LVL_IDLE = 2'd1,
    LVL_CMP  = 2'd2,
    LVL_DN   = 2'd3
  } lvl_state_e;

  // All-ones key of the requested width, right-aligned in 64 bits.
  function automatic logic [63:0] sentinel_key(input int width);
    return {64{1'b1}} >> (64 - width);
  endfunction

  // Parent index width for a level; level 1 has a single parent but keeps one bit.
  function automatic int idx_w(input int level);
    return (level > 1) ? level - 1 : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/heap_min3.sv
`default_nettype none
// +------------------------------------------------------------------+
// | heap_min3: min of {key, c0, c1}; key wins ties, c0 beats c1       |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module heap_min3 #(
  parameter int KEY_W = 16
) (
  input  logic [KEY_W-1:0] key,
  input  logic [KEY_W-1:0] c0,
  input  logic [KEY_W-1:0] c1,
  output logic [KEY_W-1:0] min_key,
  output logic             swap,
  output logic             sel
);

  logic [KEY_W-1:0] child_min;

  always_comb begin
    sel       = (c1 < c0);
    child_min = sel ? c1 : c0;
    swap      = (key > child_min);
    min_key   = swap ? child_min : key;
  end

endmodule
`default_nettype wire

// File: rtl/heap_level_engine.sv
`default_nettype none
// +------------------------------------------------------------------+
// | heap_level_engine: sift-down step for one BRAM-resident heap level|
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module heap_level_engine
  import hybrid_tree_pkg::*;
#(
  parameter int KEY_W = 16,
  parameter int LEVEL = 10,
  localparam int IDX_W = idx_w(LEVEL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic [KEY_W-1:0] in_key,
  output logic             up_valid,
  output logic [KEY_W-1:0] up_key,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [LEVEL-1:0] dn_idx,
  output logic [KEY_W-1:0] dn_key,
  output logic             init_busy,
  output logic             ram_ena,
  output logic             ram_wea,
  output logic [31:0]      ram_addra,
  output logic [KEY_W-1:0] ram_dia,
  input  logic [KEY_W-1:0] ram_doa,
  output logic             ram_enb,
  output logic             ram_web,
  output logic [31:0]      ram_addrb,
  output logic [KEY_W-1:0] ram_dib,
  input  logic [KEY_W-1:0] ram_dob
);

  localparam int DEPTH = 2 ** LEVEL;
  localparam logic [63:0]      SENT_FULL = sentinel_key(KEY_W);
  localparam logic [KEY_W-1:0] SENTINEL  = SENT_FULL[KEY_W-1:0];
  localparam logic [IDX_W-1:0] INIT_LAST = IDX_W'(DEPTH / 2 - 1);

  localparam logic [1:0] ST_INIT = LVL_INIT;
  localparam logic [1:0] ST_IDLE = LVL_IDLE;
  localparam logic [1:0] ST_CMP  = LVL_CMP;
  localparam logic [1:0] ST_DN   = LVL_DN;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             up_valid_q, up_valid_d;
  logic [KEY_W-1:0] up_key_q, up_key_d;
  logic             dn_valid_q, dn_valid_d;
  logic [LEVEL-1:0] dn_idx_q, dn_idx_d;
  logic [KEY_W-1:0] dn_key_q, dn_key_d;

  logic [KEY_W-1:0] min_key;
  logic             min_swap;
  logic             min_sel;

  heap_min3 #(.KEY_W(KEY_W)) u_min3 (
    .key     (key_q),
    .c0      (ram_doa),
    .c1      (ram_dob),
    .min_key (min_key),
    .swap    (min_swap),
    .sel     (min_sel)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign init_busy = (state_q == ST_INIT);
  assign up_valid  = up_valid_q;
  assign up_key    = up_key_q;
  assign dn_valid  = dn_valid_q;
  assign dn_idx    = dn_idx_q;
  assign dn_key    = dn_key_q;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    idx_d      = idx_q;
    key_d      = key_q;
    up_valid_d = 1'b0;
    up_key_d   = up_key_q;
    dn_valid_d = dn_valid_q;
    dn_idx_d   = dn_idx_q;
    dn_key_d   = dn_key_q;
    ram_ena    = 1'b0;
    ram_wea    = 1'b0;
    ram_addra  = '0;
    ram_dia    = '0;
    ram_enb    = 1'b0;
    ram_web    = 1'b0;
    ram_addrb  = '0;
    ram_dib    = '0;

    case (state_q)
      ST_INIT: begin
        ram_ena   = 1'b1;
        ram_wea   = 1'b1;
        ram_addra = {31'(init_cnt_q), 1'b0};
        ram_dia   = SENTINEL;
        ram_enb   = 1'b1;
        ram_web   = 1'b1;
        ram_addrb = {31'(init_cnt_q), 1'b1};
        ram_dib   = SENTINEL;
        if (init_cnt_q == INIT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          init_cnt_d = init_cnt_q + IDX_W'(1);
        end
      end
      ST_IDLE: begin
        if (in_valid) begin
          key_d     = in_key;
          idx_d     = in_idx;
          ram_ena   = 1'b1;
          ram_addra = {31'(in_idx), 1'b0};
          ram_enb   = 1'b1;
          ram_addrb = {31'(in_idx), 1'b1};
          state_d   = ST_CMP;
        end
      end
      ST_CMP: begin
        up_valid_d = 1'b1;
        up_key_d   = min_key;
        if (min_swap) begin
          // The displaced key overwrites the winning child through its own port.
          if (min_sel) begin
            ram_enb   = 1'b1;
            ram_web   = 1'b1;
            ram_addrb = {31'(idx_q), 1'b1};
            ram_dib   = key_q;
          end else begin
            ram_ena   = 1'b1;
            ram_wea   = 1'b1;
            ram_addra = {31'(idx_q), 1'b0};
            ram_dia   = key_q;
          end
          dn_valid_d = 1'b1;
          dn_idx_d   = LEVEL'({idx_q, min_sel});
          dn_key_d   = key_q;
          state_d    = ST_DN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DN: begin
        if (dn_ready) begin
          dn_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // Keep the RAM quiet while reset is held so nothing is written before INIT starts.
    if (rst) begin
      ram_ena = 1'b0;
      ram_wea = 1'b0;
      ram_enb = 1'b0;
      ram_web = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      idx_q      <= '0;
      key_q      <= '0;
      up_valid_q <= 1'b0;
      up_key_q   <= '0;
      dn_valid_q <= 1'b0;
      dn_idx_q   <= '0;
      dn_key_q   <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      idx_q      <= idx_d;
      key_q      <= key_d;
      up_valid_q <= up_valid_d;
      up_key_q   <= up_key_d;
      dn_valid_q <= dn_valid_d;
      dn_idx_q   <= dn_idx_d;
      dn_key_q   <= dn_key_d;
    end
  end

endmodule
`default_nettype wire
